axi_dmem_slave: RTL and testbench

- AXI4-Lite slave data memory; sits directly downstream of the core's load/store stage and serves its AW/W/B and AR/R channels.
- Word-organised synchronous RAM with byte-strobe writes and a registered read path.
- Read and write channels are fully independent; each has at most one outstanding transaction.

---
 rtl/axi_dmem_slave_if.sv | 62 ++++++
 rtl/axi_dmem_slave.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi_dmem_slave.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dmem_slave_if.sv
// ============================================================================
// axi_dmem_slave_if
// ----------------------------------------------------------------------------
// Purpose : AXI4-Lite bus bundle between the load/store stage (master) and
//           the data memory (slave). It carries the AW/W/B write channels and
//           the AR/R read channels. Clock and reset are not part of the bundle.
//
// Signals (master view):
//   AXI_AWADDR  out  AXI_AWIDTH  write byte address
//   AXI_AWVALID out  1           write address valid
//   AXI_AWREADY in   1           write address accepted
//   AXI_WDATA   out  AXI_DWIDTH  write data, lane-aligned
//   AXI_WSTRB   out  4           byte enables
//   AXI_WVALID  out  1           write data valid
//   AXI_WREADY  in   1           write data accepted
//   AXI_BRESP   in   2           write response (00 OKAY, 10 SLVERR)
//   AXI_BVALID  in   1           write response valid
//   AXI_BREADY  out  1           master accepts write response
//   AXI_ARADDR  out  AXI_AWIDTH  read byte address
//   AXI_ARVALID out  1           read address valid
//   AXI_ARREADY in   1           read address accepted
//   AXI_RDATA   in   AXI_DWIDTH  read data, full word
//   AXI_RRESP   in   2           read response (00 OKAY, 10 SLVERR)
//   AXI_RVALID  in   1           read data valid
//   AXI_RREADY  out  1           master accepts read data
// ============================================================================
interface axi_dmem_slave_if #(
    parameter int AXI_AWIDTH = 12,
    parameter int AXI_DWIDTH = 32
);
    logic [AXI_AWIDTH-1:0]   AXI_AWADDR;
    logic                    AXI_AWVALID;
    logic                    AXI_AWREADY;
    logic [AXI_DWIDTH-1:0]   AXI_WDATA;
    logic [AXI_DWIDTH/8-1:0] AXI_WSTRB;
    logic                    AXI_WVALID;
    logic                    AXI_WREADY;
    logic [1:0]              AXI_BRESP;
    logic                    AXI_BVALID;
    logic                    AXI_BREADY;
    logic [AXI_AWIDTH-1:0]   AXI_ARADDR;
    logic                    AXI_ARVALID;
    logic                    AXI_ARREADY;
    logic [AXI_DWIDTH-1:0]   AXI_RDATA;
    logic [1:0]              AXI_RRESP;
    logic                    AXI_RVALID;
    logic                    AXI_RREADY;

    modport master (
        output AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_BREADY,
               AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
        input  AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID,
               AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID
    );

    modport slave (
        input  AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_BREADY,
               AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
        output AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID,
               AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID
    );
endinterface

// File: rtl/axi_dmem_slave.sv
// ============================================================================
// axi_dmem_slave
// ----------------------------------------------------------------------------
// Purpose : AXI4-Lite slave data memory. It holds a word-organised
//           synchronous RAM with byte-strobe writes and a registered read path.
//           The read and write channels are independent, and each allows at
//           most one outstanding transaction.
//
// Parameters:
//   AXI_AWIDTH  byte-address width. The word index is ADDR[AXI_AWIDTH-1:2].
//   AXI_DWIDTH  data width. Only 32 is supported.
//   MEM_WORDS   number of implemented words. It must be <= 2^(AXI_AWIDTH-2).
//               Any word index at or above MEM_WORDS gets an SLVERR response.
//
// Ports:
//   CLK   in     rising-edge clock
//   NRST  in     asynchronous active-low reset; it clears all control and
//                outputs but leaves the RAM contents untouched
//   axi   slave  AXI4-Lite bundle (AW/W/B, AR/R)
//
// Timing (best case):
//   Write : AWVALID&WVALID -> READY pulse -> handshake -> commit -> BVALID.
//           This takes 3 cycles.
//   Read  : ARVALID -> ARREADY pulse -> handshake (RAM read) -> RVALID.
//           This takes 2 cycles.
//   A commit and an AR handshake on the same edge to the same word return
//   the old word (read-before-write).
// ============================================================================
module axi_dmem_slave #(
    parameter int AXI_AWIDTH = 12,
    parameter int AXI_DWIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic              CLK,
    input  logic              NRST,
    axi_dmem_slave_if.slave   axi
);

    localparam int IDX_W  = AXI_AWIDTH - 2;
    localparam int RAM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [AXI_DWIDTH-1:0] r_mem [0:MEM_WORDS-1];

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_t              r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [IDX_W-1:0]      r_aw_idx;
    logic [AXI_DWIDTH-1:0] r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_have_addr;
    logic                  w_have_data;
    logic                  w_wr_in_range;
    logic [RAM_AW-1:0]     w_wr_ram_idx;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    r_state_t              r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic                  r_rd_ok;
    logic [AXI_DWIDTH-1:0] r_ram_q;

    logic                  w_ar_hs;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_rd_in_range;
    logic [RAM_AW-1:0]     w_rd_ram_idx;

    // The byte-offset bits take no part in word addressing.
    logic                  w_unused_addr_bits;
    assign w_unused_addr_bits = ^{axi.AXI_AWADDR[1:0], axi.AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------
    // Write-side decode
    // ------------------------------------------------------------------
    assign w_aw_hs     = axi.AXI_AWVALID && r_awready;
    assign w_w_hs      = axi.AXI_WVALID  && r_wready;
    // The address or data counts as present on the handshake edge itself,
    // so that an AW and W arriving together go straight to the commit.
    assign w_have_addr = r_aw_held || w_aw_hs;
    assign w_have_data = r_w_held  || w_w_hs;

    assign w_wr_in_range = (32'(r_aw_idx) < MEM_WORDS);
    assign w_wr_ram_idx  = r_aw_idx[RAM_AW-1:0];

    // ------------------------------------------------------------------
    // Write FSM: collect AW and W in any order, commit for one cycle,
    // then hold B until the master takes it.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    // READY is a one-cycle pulse raised only in response to
                    // VALID. If VALID is dropped illegally, the pulse simply
                    // expires and the channel keeps waiting.
                    r_awready <= axi.AXI_AWVALID && !r_aw_held && !r_awready;
                    r_wready  <= axi.AXI_WVALID  && !r_w_held  && !r_wready;
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_aw_idx  <= axi.AXI_AWADDR[AXI_AWIDTH-1:2];
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= axi.AXI_WDATA;
                        r_wstrb  <= axi.AXI_WSTRB;
                    end
                    if (w_have_addr && w_have_data) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_wstate  <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    // The RAM is written on this edge (see the RAM process).
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_bresp   <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    r_wstate  <= W_RESP;
                end
                W_RESP: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    if (axi.AXI_BREADY) begin
                        r_bvalid <= 1'b0;
                        r_bresp  <= RESP_OKAY;
                        r_wstate <= W_IDLE;
                    end
                end
                default: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_bresp   <= RESP_OKAY;
                    r_wstate  <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-side decode
    // ------------------------------------------------------------------
    assign w_ar_hs       = axi.AXI_ARVALID && r_arready;
    assign w_rd_idx      = axi.AXI_ARADDR[AXI_AWIDTH-1:2];
    assign w_rd_in_range = (32'(w_rd_idx) < MEM_WORDS);
    assign w_rd_ram_idx  = w_rd_idx[RAM_AW-1:0];

    // ------------------------------------------------------------------
    // Read FSM: the RAM is sampled on the AR handshake edge, and R is then
    // held until the master takes it.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rd_ok   <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= axi.AXI_ARVALID && !r_arready;
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rresp   <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        r_rd_ok   <= w_rd_in_range;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    r_arready <= 1'b0;
                    if (axi.AXI_RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rresp  <= RESP_OKAY;
                        r_rd_ok  <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: begin
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rresp   <= RESP_OKAY;
                    r_rd_ok   <= 1'b0;
                    r_rstate  <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RAM array. It has no reset so that it maps onto plain synchronous
    // memory. On a shared edge the read port samples the pre-write word.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (r_wstate == W_COMMIT && w_wr_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_wr_ram_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
        if (w_ar_hs && w_rd_in_range) begin
            r_ram_q <= r_mem[w_rd_ram_idx];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign axi.AXI_AWREADY = r_awready;
    assign axi.AXI_WREADY  = r_wready;
    assign axi.AXI_BVALID  = r_bvalid;
    assign axi.AXI_BRESP   = r_bresp;
    assign axi.AXI_ARREADY = r_arready;
    assign axi.AXI_RVALID  = r_rvalid;
    assign axi.AXI_RRESP   = r_rresp;
    // The RAM output register has no reset. Gating it with a reset-cleared
    // flag makes RDATA zero in reset and for out-of-range reads.
    assign axi.AXI_RDATA   = r_rd_ok ? r_ram_q : '0;

endmodule

// File: tb/tb_axi_dmem_slave.sv
module tb_axi_dmem_slave;

    localparam int AW = 13;
    localparam int MW = 1024;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    axi_dmem_slave_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(32)) bus ();

    axi_dmem_slave #(
        .AXI_AWIDTH(AW),
        .AXI_DWIDTH(32),
        .MEM_WORDS (MW)
    ) dut (
        .CLK (clk),
        .NRST(nrst),
        .axi (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory: an array of words updated by byte enables.
    logic [31:0] model [0:MW-1];
    logic [1:0]  exp_bresp = 2'b00;
    logic [1:0]  exp_rresp = 2'b00;
    logic [31:0] exp_rdata = 32'h0;
    bit          mon_en    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drop_all();
        bus.AXI_AWVALID = 1'b0;
        bus.AXI_WVALID  = 1'b0;
        bus.AXI_BREADY  = 1'b0;
        bus.AXI_ARVALID = 1'b0;
        bus.AXI_RREADY  = 1'b0;
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_BVALID, bus.AXI_BRESP,
                    bus.AXI_ARREADY, bus.AXI_RVALID, bus.AXI_RRESP, bus.AXI_RDATA});
    endfunction

    // This is called 2 time units before a rising edge. It pulls reset
    // mid-cycle, checks that the outputs clear at once, then releases.
    task automatic reset_mid(input string name);
        nrst = 1'b0;
        #1;
        chk(name, all_outputs(), 64'h0);
        drop_all();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    // Per-cycle compare of the live outputs against the reference expectations.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (mon_en && nrst) begin
                if (bus.AXI_BVALID) chk("mon_bresp", 64'(bus.AXI_BRESP), 64'(exp_bresp));
                if (bus.AXI_RVALID) begin
                    chk("mon_rdata", 64'(bus.AXI_RDATA), 64'(exp_rdata));
                    chk("mon_rresp", 64'(bus.AXI_RRESP), 64'(exp_rresp));
                end
                chk("mon_ready_without_valid",
                    64'({bus.AXI_AWREADY & ~bus.AXI_AWVALID,
                         bus.AXI_WREADY  & ~bus.AXI_WVALID,
                         bus.AXI_ARREADY & ~bus.AXI_ARVALID}), 64'h0);
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, input bit poke, input int rst_at,
                            output logic [1:0] bresp);
        int idx, cyc, b_first, exp_lat;
        bit aw_done, w_done, b_done, rst_hit;
        idx       = int'(addr[AW-1:2]);
        exp_bresp = (idx >= MW) ? 2'b10 : 2'b00;
        exp_lat   = ((aw_dly > w_dly) ? aw_dly : w_dly) + 3;
        aw_done = 0; w_done = 0; b_done = 0; rst_hit = 0;
        b_first = -1; cyc = 0; bresp = 2'bxx;
        while (!b_done && !rst_hit && cyc < 60) begin
            @(negedge clk);
            bus.AXI_AWADDR  = addr;
            bus.AXI_WDATA   = data;
            bus.AXI_WSTRB   = strb;
            bus.AXI_AWVALID = (!aw_done && cyc >= aw_dly) || (poke && b_first >= 0);
            bus.AXI_WVALID  = (!w_done && cyc >= w_dly) || (poke && b_first >= 0);
            bus.AXI_BREADY  = (b_dly == 0) || (b_first >= 0 && cyc - b_first >= b_dly);
            #3;
            if (poke && b_first >= 0)
                chk("wr_blocked_during_b", 64'({bus.AXI_AWREADY, bus.AXI_WREADY}), 64'h0);
            if (!aw_done && bus.AXI_AWVALID && bus.AXI_AWREADY) aw_done = 1;
            if (!w_done && bus.AXI_WVALID && bus.AXI_WREADY) w_done = 1;
            if (bus.AXI_BVALID && b_first < 0) begin
                b_first = cyc;
                bresp   = bus.AXI_BRESP;
            end
            if (rst_at >= 0 && b_first >= 0 && cyc - b_first == rst_at) begin
                reset_mid("reset_during_bvalid");
                rst_hit = 1;
            end else if (bus.AXI_BVALID && bus.AXI_BREADY) begin
                b_done = 1;
            end
            cyc++;
        end
        if (!rst_hit) begin
            chk("wr_b_handshake", 64'(b_done), 64'h1);
            chk("wr_b_latency", 64'(b_first), 64'(exp_lat));
            @(negedge clk);
            drop_all();
            #3;
            chk("wr_single_bvalid", 64'(bus.AXI_BVALID), 64'h0);
        end
        // Once BVALID has been seen, the commit edge is behind us.
        if ((b_done || rst_hit) && idx < MW)
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int r_dly, input bit poke,
                           input int rst_at, output logic [31:0] rdata,
                           output logic [1:0] rresp);
        int idx, cyc, r_first;
        bit ar_done, r_done, rst_hit;
        idx       = int'(addr[AW-1:2]);
        exp_rresp = (idx >= MW) ? 2'b10 : 2'b00;
        exp_rdata = (idx >= MW) ? 32'h0 : model[idx];
        ar_done = 0; r_done = 0; rst_hit = 0; r_first = -1; cyc = 0;
        rdata = 'x; rresp = 'x;
        while (!r_done && !rst_hit && cyc < 60) begin
            @(negedge clk);
            bus.AXI_ARADDR  = addr;
            bus.AXI_ARVALID = !ar_done || (poke && r_first >= 0);
            bus.AXI_RREADY  = (r_dly == 0) || (r_first >= 0 && cyc - r_first >= r_dly);
            #3;
            if (poke && r_first >= 0)
                chk("rd_blocked_during_r", 64'(bus.AXI_ARREADY), 64'h0);
            if (!ar_done && bus.AXI_ARVALID && bus.AXI_ARREADY) ar_done = 1;
            if (bus.AXI_RVALID && r_first < 0) begin
                r_first = cyc;
                rdata   = bus.AXI_RDATA;
                rresp   = bus.AXI_RRESP;
            end
            if (rst_at >= 0 && r_first >= 0 && cyc - r_first == rst_at) begin
                reset_mid("reset_during_rvalid");
                rst_hit = 1;
            end else if (bus.AXI_RVALID && bus.AXI_RREADY) begin
                r_done = 1;
            end
            cyc++;
        end
        if (!rst_hit) begin
            chk("rd_r_handshake", 64'(r_done), 64'h1);
            chk("rd_r_latency", 64'(r_first), 64'd2);
            @(negedge clk);
            drop_all();
            #3;
            chk("rd_single_rvalid", 64'(bus.AXI_RVALID), 64'h0);
        end
    endtask

    initial begin
        logic [1:0]    br, rr;
        logic [31:0]   rd;
        logic [AW-1:0] a;
        int            idx;

        bus.AXI_AWADDR = '0; bus.AXI_WDATA = '0; bus.AXI_WSTRB = '0;
        bus.AXI_ARADDR = '0;
        drop_all();

        repeat (3) @(negedge clk);
        #3;
        chk("reset_outputs_zero", all_outputs(), 64'h0);
        @(negedge clk);
        nrst   = 1'b1;
        mon_en = 1'b1;

        // Give known contents to every word the random phase may read.
        for (int i = 0; i < 16; i++)
            do_write(AW'(i * 4), $urandom, 4'hF, 0, 0, 0, 0, -1, br);
        for (int i = MW - 4; i < MW; i++)
            do_write(AW'(i * 4), $urandom, 4'hF, 0, 0, 0, 0, -1, br);
        do_write(13'h000, 32'h01234567, 4'hF, 0, 0, 0, 0, -1, br);

        // Aligned write, then read back.
        do_write(13'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, -1, br);
        chk("aligned_bresp", 64'(br), 64'h0);
        do_read(13'h010, 0, 0, -1, rd, rr);
        chk("aligned_rdata", 64'(rd), 64'hDEADBEEF);
        chk("aligned_rresp", 64'(rr), 64'h0);

        // Byte strobes.
        do_write(13'h020, 32'h11223344, 4'hF, 0, 0, 0, 0, -1, br);
        do_write(13'h020, 32'h0000AA00, 4'b0010, 0, 0, 0, 0, -1, br);
        do_read(13'h020, 0, 0, -1, rd, rr);
        chk("strobe_byte1_rdata", 64'(rd), 64'h1122AA44);
        do_write(13'h020, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0, -1, br);
        chk("strobe_none_bresp", 64'(br), 64'h0);
        do_read(13'h020, 0, 0, -1, rd, rr);
        chk("strobe_none_rdata", 64'(rd), 64'h1122AA44);

        // Channel ordering: W four cycles ahead, then AW ahead.
        do_write(13'h030, 32'hCAFEF00D, 4'hF, 4, 0, 0, 0, -1, br);
        do_read(13'h030, 0, 0, -1, rd, rr);
        chk("w_first_rdata", 64'(rd), 64'hCAFEF00D);
        do_write(13'h034, 32'h0BADC0DE, 4'hF, 0, 4, 0, 0, -1, br);
        do_read(13'h034, 0, 0, -1, rd, rr);
        chk("aw_first_rdata", 64'(rd), 64'h0BADC0DE);

        // Backpressure, with a second request poked during the stall.
        do_write(13'h038, 32'hA5A5A5A5, 4'hF, 0, 0, 5, 1, -1, br);
        do_read(13'h038, 5, 1, -1, rd, rr);
        chk("backpressure_rdata", 64'(rd), 64'hA5A5A5A5);

        // Out of range. Index 1024 would alias word 0 if it were truncated.
        do_write(13'h1000, 32'hFFFF0000, 4'hF, 0, 0, 0, 0, -1, br);
        chk("oor_bresp", 64'(br), 64'h2);
        do_read(13'h1000, 0, 0, -1, rd, rr);
        chk("oor_rresp", 64'(rr), 64'h2);
        chk("oor_rdata", 64'(rd), 64'h0);
        do_read(13'h000, 0, 0, -1, rd, rr);
        chk("oor_no_alias_write", 64'(rd), 64'h01234567);

        // Reset while BVALID or RVALID is pending, then fresh transactions.
        do_write(13'h040, 32'h55AA55AA, 4'hF, 0, 0, 5, 0, 2, br);
        do_read(13'h040, 5, 0, 2, rd, rr);
        do_read(13'h040, 0, 0, -1, rd, rr);
        chk("after_reset_committed_rdata", 64'(rd), 64'h55AA55AA);
        do_write(13'h044, 32'h76543210, 4'hF, 0, 0, 0, 0, -1, br);
        chk("after_reset_bresp", 64'(br), 64'h0);
        do_read(13'h044, 0, 0, -1, rd, rr);
        chk("after_reset_rdata", 64'(rd), 64'h76543210);

        // Randomized traffic checked against the reference memory.
        for (int k = 0; k < 160; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)     idx = int'($urandom_range(MW, 2 * MW - 1));
            else if (r < 3) idx = int'($urandom_range(MW - 4, MW - 1));
            else            idx = int'($urandom_range(0, 15));
            a = AW'(idx * 4 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         ($urandom_range(0, 3) == 0), -1, br);
            else
                do_read(a, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                        -1, rd, rr);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
